serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 95 +++++++++
 tb/tb_serial_subtractor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one difference bit per clock, LSB first,
// with a registered result and final borrow held until the next completion.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] out,
    output logic             bout,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Handshake: start is a request sampled only in IDLE (ignored otherwise,
    // never queued); busy is high from the accepting edge until the return to
    // IDLE; done is a one-cycle strobe that coincides with the new out/bout.

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    cnt;
    logic             br;

    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] r_next;

    always_comb begin
        d_bit   = a_q[0] ^ b_q[0] ^ br;
        br_next = (~a_q[0] & b_q[0]) | (~a_q[0] & br) | (b_q[0] & br);
        r_next  = {d_bit, r_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            out   <= '0;
            bout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= data_a;
                        b_q   <= data_b;
                        r_q   <= '0;
                        cnt   <= '0;
                        br    <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q <= a_q >> 1;
                    b_q <= b_q >> 1;
                    r_q <= r_next;
                    br  <= br_next;
                    cnt <= cnt + 1'b1;
                    // Result registers move only on the final bit so out never shows a partial value.
                    if (cnt == LAST) begin
                        out   <= r_next;
                        bout  <= br_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == SHIFT) || (state == DONE);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and back-to-back random checks of serial_subtractor against a
// cycle-level model with a result scoreboard.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [WIDTH-1:0] out;
    logic             bout;
    logic             busy;
    logic             done;
    logic [1:0]       state_dbg;

    int cmp_cnt = 0;
    int err_cnt = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .data_a    (data_a),
        .data_b    (data_b),
        .out       (out),
        .bout      (bout),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH:0] model_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] d;
        d = a - b;
        return {(a < b), d};
    endfunction

    // Model: cycles remaining until IDLE (WIDTH SHIFT cycles, then one DONE).
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] exp_last;
    int             model_cnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            model_cnt <= 0;
            exp_q.delete();
            exp_last  <= '0;
        end else if (model_cnt == 0) begin
            if (start) begin
                exp_q.push_back(model_sub(data_a, data_b));
                model_cnt <= WIDTH + 1;
            end
        end else begin
            if (model_cnt == 2) begin
                chk("sb_nonempty", 33'(exp_q.size() != 0), 33'd1);
                if (exp_q.size() != 0) exp_last <= exp_q.pop_front();
            end
            model_cnt <= model_cnt - 1;
        end
    end

    // Per-cycle monitor, sampled on the falling edge
    int done_cnt      = 0;
    int last_done_cyc = -1;
    bit b2b           = 1'b0;

    always @(negedge clk) begin
        logic [1:0] exp_state;
        exp_state = (model_cnt == 0) ? 2'd0 : (model_cnt == 1) ? 2'd2 : 2'd1;
        chk("busy", 33'(busy), 33'(model_cnt != 0));
        chk("done", 33'(done), 33'(model_cnt == 1));
        chk("state", 33'(state_dbg), 33'(exp_state));
        chk("result", 33'({bout, out}), 33'(exp_last));
        if (done === 1'b1) begin
            // An idle cycle separates completion from the next accept.
            if (b2b && last_done_cyc >= 0)
                chk("b2b_spacing", 33'(cyc - last_done_cyc), 33'(WIDTH + 2));
            last_done_cyc = cyc;
            done_cnt++;
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_out, input logic exp_bout);
        int d0;
        d0     = done_cnt;
        start  = 1'b1;
        data_a = a;
        data_b = b;
        tick(1);
        start  = 1'b0;
        data_a = WIDTH'($urandom_range(0, 255));
        data_b = WIDTH'($urandom_range(0, 255));
        tick(WIDTH + 1);
        chk(tag, 33'({bout, out}), 33'({exp_bout, exp_out}));
        chk({tag, "_done_once"}, 33'(done_cnt - d0), 33'd1);
    endtask

    initial begin
        int d0;
        int target;
        int budget;

        reset  = 1'b0;
        start  = 1'b0;
        data_a = '0;
        data_b = '0;
        tick(3);
        chk("reset_out", 33'({bout, out}), 33'd0);
        chk("reset_busy", 33'({busy, done}), 33'd0);
        reset = 1'b1;
        tick(2);

        run_op("sub_27_21",   8'd27,  8'd21,  8'd6,   1'b0);
        run_op("sub_21_27",   8'd21,  8'd27,  8'hFA,  1'b1);
        run_op("sub_0_0",     8'd0,   8'd0,   8'd0,   1'b0);
        run_op("sub_255_1",   8'd255, 8'd1,   8'd254, 1'b0);
        run_op("sub_0_255",   8'd0,   8'd255, 8'd1,   1'b1);
        run_op("sub_128_128", 8'd128, 8'd128, 8'd0,   1'b0);
        run_op("sub_77_0",    8'd77,  8'd0,   8'd77,  1'b0);
        run_op("sub_0_1",     8'd0,   8'd1,   8'hFF,  1'b1);

        // Second request and operand changes during SHIFT are ignored
        d0     = done_cnt;
        start  = 1'b1;
        data_a = 8'd200;
        data_b = 8'd100;
        tick(1);
        start  = 1'b0;
        tick(2);
        start  = 1'b1;
        data_a = 8'd5;
        data_b = 8'd3;
        tick(1);
        start  = 1'b0;
        data_a = 8'd77;
        data_b = 8'd99;
        tick(WIDTH - 2);
        chk("stable_200_100", 33'({bout, out}), 33'({1'b0, 8'd100}));
        tick(WIDTH + 2);
        chk("stable_one_done", 33'(done_cnt - d0), 33'd1);

        // Asynchronous reset mid-operation, then start on the first edge after release
        start  = 1'b1;
        data_a = 8'd27;
        data_b = 8'd21;
        tick(1);
        start = 1'b0;
        tick(3);
        d0 = done_cnt;
        #2 reset = 1'b0;
        #1;
        chk("abort_out", 33'({bout, out}), 33'd0);
        chk("abort_busy", 33'({busy, done}), 33'd0);
        tick(1);
        start  = 1'b1;
        data_a = 8'd9;
        data_b = 8'd4;
        #2 reset = 1'b1;
        tick(1);
        start = 1'b0;
        tick(WIDTH + 1);
        chk("after_reset_9_4", 33'({bout, out}), 33'({1'b0, 8'd5}));
        chk("abort_no_done", 33'(done_cnt - d0), 33'd1);

        // Back-to-back random operands with start held high
        b2b           = 1'b1;
        last_done_cyc = -1;
        target        = done_cnt + 1000;
        budget        = 1000 * (WIDTH + 2) + 50;
        start         = 1'b1;
        while (done_cnt < target && budget > 0) begin
            data_a = WIDTH'($urandom_range(0, 255));
            data_b = WIDTH'($urandom_range(0, 255));
            tick(1);
            budget--;
        end
        start = 1'b0;
        chk("b2b_count", 33'(done_cnt), 33'(target));
        b2b = 1'b0;
        tick(WIDTH + 3);
        chk("sb_drained", 33'(exp_q.size()), 33'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
